// File: rtl/mmda_seq.sv
// Control sequencer for the 3x3 distributed-arithmetic matrix-vector unit.
// Optional signed-MSB subtract step is enabled by defining MMDA_SIGNED_EN.
module mmda_seq #(
    parameter int DW  = 8,
    parameter int CW  = 5,
    parameter int OCW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic           res_ready,
    input  logic           abort,
    output logic           ld_en,
    output logic           acc_clr,
    output logic           acc_en,
    output logic           acc_sub,
    output logic [CW-1:0]  bit_idx,
    output logic           res_valid,
    output logic           busy,
    output logic [OCW-1:0] op_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_bit_idx;
    logic [CW-1:0]  w_bit_idx_nxt;
    logic [OCW-1:0] r_op_cnt;
    logic [OCW-1:0] w_op_cnt_nxt;
    logic           w_last;

    assign w_last = (r_bit_idx == CW'(DW - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_op_cnt  <= '0;
        end else begin
            r_state   <= w_next;
            r_bit_idx <= w_bit_idx_nxt;
            r_op_cnt  <= w_op_cnt_nxt;
        end
    end

    // abort outranks every other input, including a pending result handshake
    always_comb begin
        w_next        = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_op_cnt_nxt  = r_op_cnt;
        if (abort) begin
            w_next        = S_IDLE;
            w_bit_idx_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        w_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_next        = S_RUN;
                    w_bit_idx_nxt = '0;
                end
                S_RUN: begin
                    if (w_last) begin
                        w_next        = S_HOLD;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        w_next       = S_IDLE;
                        w_op_cnt_nxt = r_op_cnt + 1'b1;
                    end
                end
                default: begin
                    w_next        = S_IDLE;
                    w_bit_idx_nxt = '0;
                end
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign ld_en       = (r_state == S_LOAD);
    assign acc_clr     = (r_state == S_LOAD);
    assign acc_en      = (r_state == S_RUN);
    assign res_valid   = (r_state == S_HOLD);
    assign bit_idx     = r_bit_idx;
    assign op_cnt      = r_op_cnt;

`ifdef MMDA_SIGNED_EN
    // two's-complement MSB carries negative weight
    assign acc_sub = (r_state == S_RUN) && w_last;
`else
    assign acc_sub = 1'b0;
`endif

endmodule

// File: doc/mmda_seq.md
Name: mmda_seq

Overview:
Sequencer for the 3x3 distributed-arithmetic matrix-vector multiplier (matrix a..j, vector c0..c2, results y0..y2).
- Accepts a start request through a valid/ready handshake.
- Drives the datapath operand-load, accumulator-clear, bit-index and accumulate-enable controls through DW bit-serial steps.
- Holds a result-valid handshake until the consumer accepts it.
- Sits between the top-level command source and the DA datapath; contains no arithmetic on matrix data.

Parameters:
DW, 8, operand bit width = number of bit-serial DA steps (legal range 2..32)
CW, 5, width of bit_idx; must satisfy 2^CW >= DW
OCW, 16, width of completed-operation counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset; clk domain only
start_valid  in  1  request to run one matrix-vector product
start_ready  out  1  high only in IDLE
res_ready  in  1  consumer accepts result
abort  in  1  synchronous cancel of current operation
ld_en  out  1  datapath captures a..j, c0..c2 into its shift registers
acc_clr  out  1  datapath clears y accumulators
acc_en  out  1  datapath adds LUT output shifted by bit_idx
acc_sub  out  1  datapath subtracts instead of adds (sign step)
bit_idx  out  CW  current DA bit position, LSB first
res_valid  out  1  y0..y2 stable and valid
busy  out  1  high in any state except IDLE
op_cnt  out  OCW  number of completed result handshakes

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE, bit_idx=0, op_cnt=0
  - ld_en=acc_clr=acc_en=acc_sub=res_valid=busy=0, start_ready=1
- All outputs are decoded from registered state/counters; no combinational path from inputs to outputs.
- States:
  - IDLE: start_ready=1. On start_valid=1 go to LOAD.
  - LOAD (exactly 1 cycle): ld_en=1, acc_clr=1. Next state RUN with bit_idx=0.
  - RUN (exactly DW cycles): acc_en=1, bit_idx counts 0..DW-1, incrementing each cycle. After the cycle with bit_idx=DW-1, go to HOLD and return bit_idx to 0.
  - HOLD: res_valid=1, held until res_ready=1. On that cycle, op_cnt increments and the next state is IDLE.
- Handshake:
  - A start is accepted only on a cycle with start_valid=1 and start_ready=1. start_valid in any other state is ignored, not queued.
  - res_ready while res_valid=0 is ignored.
- Latency:
  - Start accepted at edge T gives LOAD at T+1, RUN over T+2..T+DW+1, and res_valid from T+DW+2.
  - Minimum issue interval is DW+3 cycles (11 for DW=8).
- abort=1 (synchronous) in any state returns to IDLE on the next edge:
  - bit_idx cleared, no res_valid pulse, op_cnt unchanged.
  - abort has priority over start_valid and res_ready in the same cycle.
- Reset asserted mid-operation aborts immediately, with the same result as power-on reset.
- op_cnt wraps from 2^OCW-1 to 0 with no flag.
- acc_sub is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: MMDA_SIGNED_EN
- Defined: in RUN, acc_sub=1 exactly on the cycle with bit_idx=DW-1 (two's-complement MSB weight is negative); otherwise 0.
- Undefined: acc_sub is tied to 0 (unsigned operands); logic for it is not generated.

Test Plan:
1. Reset release, then start_valid=1 for one cycle:
   - ld_en=acc_clr=1 for exactly 1 cycle.
   - acc_en=1 for 8 cycles with bit_idx 0,1,..,7.
   - res_valid rises 10 cycles after acceptance.
   - With datapath attached, a..j=1..9 and c=1,2,3 give y0=14, y1=32, y2=50.
2. Backpressure: hold res_ready=0 for 20 cycles:
   - res_valid stays 1, start_ready stays 0, start_valid pulses are ignored.
   - res_ready=1 then drops res_valid next cycle and sets op_cnt=1.
3. abort asserted on the 4th RUN cycle (bit_idx=3):
   - Next cycle is IDLE, busy=0, no res_valid, op_cnt unchanged.
   - A new start then produces a full 8-step sequence.
4. reset driven low mid-RUN (asynchronous, off clock edge):
   - All outputs return to reset values immediately.
   - After release, the sequence restarts cleanly on the next start.
5. Back-to-back: start_valid held high with res_ready held high:
   - Operations issue every 11 cycles.
   - op_cnt preset near wrap (OCW=4) rolls 15->0.
6. MMDA_SIGNED_EN defined: acc_sub=1 only when bit_idx=7; with c0=-1 (8'hFF), c1=c2=0, y0 = -a.
   - Undefined: acc_sub is never 1.
